// File: rtl/i_pd_seq_pkg.sv
// Shared types and Q-format helpers for the sequential I-PD servo controller.
package i_pd_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MUL_I = 3'd1,
      MUL_P = 3'd2,
      MUL_D = 3'd3,
      SUM   = 3'd4
   } state_t;

   localparam int     FRAC_DEFAULT = 10;
   localparam longint ONE          = 64'sd1 <<< FRAC_DEFAULT;

   function automatic longint sat_resize(input longint value, input int width);
      longint hi;
      longint lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi)
         return hi;
      else if (value < lo)
         return lo;
      return value;
   endfunction

   function automatic longint q_mul_shift(input longint a, input longint b, input int frac);
      return (a * b) >>> frac;
   endfunction

endpackage

// File: rtl/i_pd_seq_if.sv
// Sample/handshake bundle between the position sampler, the controller and the PWM stage.
interface i_pd_seq_if #(
   parameter int WIDTH = 18
);
   logic                    enable;
   logic                    clear_int;
   logic signed [WIDTH-1:0] referencia;
   logic signed [WIDTH-1:0] y;
   logic signed [WIDTH-1:0] kp;
   logic signed [WIDTH-1:0] ki;
   logic signed [WIDTH-1:0] kd;
   logic signed [WIDTH-1:0] IPD;
   logic                    valid;
   logic                    busy;
   logic                    sat_hi;
   logic                    sat_lo;

   modport master (
      output enable, clear_int, referencia, y, kp, ki, kd,
      input  IPD, valid, busy, sat_hi, sat_lo
   );

   modport slave (
      input  enable, clear_int, referencia, y, kp, ki, kd,
      output IPD, valid, busy, sat_hi, sat_lo
   );
endinterface

// File: rtl/i_pd_seq_sat.sv
// Saturating signed resize from IN_W to OUT_W bits into [LO_LIM, HI_LIM]; IN_W must exceed OUT_W.
module sat_signed #(
   parameter int                      IN_W   = 37,
   parameter int                      OUT_W  = 18,
   parameter logic signed [OUT_W-1:0] HI_LIM = {1'b0, {(OUT_W-1){1'b1}}},
   parameter logic signed [OUT_W-1:0] LO_LIM = {1'b1, {(OUT_W-1){1'b0}}}
) (
   input  logic signed [IN_W-1:0]  value,
   output logic signed [OUT_W-1:0] result,
   output logic                    hi,
   output logic                    lo
);
   localparam logic signed [IN_W-1:0] HI_EXT = {{(IN_W-OUT_W){HI_LIM[OUT_W-1]}}, HI_LIM};
   localparam logic signed [IN_W-1:0] LO_EXT = {{(IN_W-OUT_W){LO_LIM[OUT_W-1]}}, LO_LIM};

   always_comb begin
      hi     = value > HI_EXT;
      lo     = value < LO_EXT;
      result = value[OUT_W-1:0];
      if (hi)
         result = HI_LIM;
      else if (lo)
         result = LO_LIM;
   end
endmodule

// File: rtl/i_pd_seq.sv
// Sequential I-PD controller: one shared multiplier walks ki*e, kp*y, kd*dy, then sums and clamps.
module i_pd_seq
   import i_pd_pkg::*;
#(
   parameter int                      WIDTH   = 18,
   parameter int                      FRAC    = 10,
   parameter logic signed [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}},
   parameter logic signed [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}}
) (
   input  logic       clk,
   input  logic       reset,
   i_pd_seq_if.slave  bus
);
   localparam int EW = WIDTH + 1;
   localparam int PW = 2 * WIDTH + 1;
   localparam int IW = 2 * WIDTH + 2;
   localparam int UW = 2 * WIDTH + 3;

   state_t state_reg, state_next;

   logic signed [WIDTH-1:0] kp_reg, ki_reg, kd_reg, y_reg, y_prev_reg;
   logic signed [EW-1:0]    e_reg, dy_reg;
   logic signed [WIDTH-1:0] integ_reg, ipd_reg;
   logic signed [PW-1:0]    pp_reg, pd_reg;
   logic                    first_reg, busy_reg, valid_reg, sat_hi_reg, sat_lo_reg;

   logic signed [WIDTH-1:0] mul_a;
   logic signed [EW-1:0]    mul_b;
   logic signed [PW-1:0]    product, term;
   logic signed [IW-1:0]    integ_sum;
   logic signed [WIDTH-1:0] integ_sat, u_clamped;
   logic signed [UW-1:0]    u_wide;
   logic [1:0]              integ_clip_unused;
   logic                    hold, clamp_hi, clamp_lo;

   always_comb begin
      mul_a = kd_reg;
      mul_b = dy_reg;
      if (state_reg == MUL_I) begin
         mul_a = ki_reg;
         mul_b = e_reg;
      end else if (state_reg == MUL_P) begin
         mul_a = kp_reg;
         mul_b = EW'(y_reg);
      end
   end

   // Full-width product and sums so no intermediate can wrap before saturation.
   assign product   = PW'(mul_a) * PW'(mul_b);
   assign term      = product >>> FRAC;
   assign integ_sum = IW'(integ_reg) + IW'(term);
   assign u_wide    = UW'(integ_reg) - UW'(pp_reg) - UW'(pd_reg);
   assign hold      = (sat_hi_reg && !term[PW-1] && (|term)) || (sat_lo_reg && term[PW-1]);

   sat_signed #(.IN_W(IW), .OUT_W(WIDTH)) u_sat_integ (
      .value(integ_sum), .result(integ_sat),
      .hi(integ_clip_unused[1]), .lo(integ_clip_unused[0])
   );

   sat_signed #(.IN_W(UW), .OUT_W(WIDTH), .HI_LIM(OUT_MAX), .LO_LIM(OUT_MIN)) u_sat_out (
      .value(u_wide), .result(u_clamped), .hi(clamp_hi), .lo(clamp_lo)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.enable) state_next = MUL_I;
         MUL_I:   state_next = MUL_P;
         MUL_P:   state_next = MUL_D;
         MUL_D:   state_next = SUM;
         SUM:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (bus.clear_int)
         state_next = IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         kp_reg <= '0; ki_reg <= '0; kd_reg <= '0; y_reg <= '0; y_prev_reg <= '0;
         e_reg <= '0; dy_reg <= '0; pp_reg <= '0; pd_reg <= '0;
         integ_reg <= '0; ipd_reg <= '0;
         first_reg <= 1'b1; busy_reg <= 1'b0; valid_reg <= 1'b0;
         sat_hi_reg <= 1'b0; sat_lo_reg <= 1'b0;
      end else if (bus.clear_int) begin
         integ_reg  <= '0;
         first_reg  <= 1'b1;
         sat_hi_reg <= 1'b0;
         sat_lo_reg <= 1'b0;
         busy_reg   <= 1'b0;
         valid_reg  <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         case (state_reg)
            IDLE: if (bus.enable) begin
               kp_reg   <= bus.kp;
               ki_reg   <= bus.ki;
               kd_reg   <= bus.kd;
               y_reg    <= bus.y;
               e_reg    <= EW'(bus.referencia) - EW'(bus.y);
               // First sample after reset/clear has no valid history: suppress the derivative kick.
               dy_reg   <= first_reg ? '0 : EW'(bus.y) - EW'(y_prev_reg);
               busy_reg <= 1'b1;
            end
            MUL_I: if (!hold) integ_reg <= integ_sat;
            MUL_P: pp_reg <= term;
            MUL_D: pd_reg <= term;
            SUM: begin
               ipd_reg    <= u_clamped;
               sat_hi_reg <= clamp_hi;
               sat_lo_reg <= clamp_lo;
               y_prev_reg <= y_reg;
               first_reg  <= 1'b0;
               busy_reg   <= 1'b0;
               valid_reg  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.IPD    = ipd_reg;
   assign bus.valid  = valid_reg;
   assign bus.busy   = busy_reg;
   assign bus.sat_hi = sat_hi_reg;
   assign bus.sat_lo = sat_lo_reg;
endmodule
